alu_cmd_seq: RTL

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

---
 rtl/alu_cmd_seq_pkg.sv | 44 ++++
 rtl/alu_cmd_fifo.sv | 54 +++++
 rtl/alu_cmd_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/alu_cmd_seq_pkg.sv
// Shared definitions for the ALU command sequencer: op encodings, command record and
// the table of instruction transitions the ALU accepts.
package alu_cmd_seq_pkg;

   typedef enum logic [2:0] {
      OpAdd  = 3'b000,
      OpSub  = 3'b001,
      OpMul  = 3'b010,
      OpAsr  = 3'b011,
      OpNsub = 3'b100,
      OpXor  = 3'b101,
      OpAbs  = 3'b110,
      OpHold = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StBridge
   } seq_state_e;

   typedef struct packed {
      alu_op_e    op;
      logic [7:0] a;
      logic [7:0] b;
   } alu_cmd_t;

   // True when the ALU may move from instruction cur to instruction nxt.
   function automatic logic op_legal(alu_op_e cur, alu_op_e nxt);
      logic [7:0] from_mask;  // bit i set: transition allowed from op i
      case (nxt)
         OpAdd:   from_mask = 8'b0010_1111;
         OpSub:   from_mask = 8'b0111_1111;
         OpMul:   from_mask = 8'b0010_0011;
         OpAsr:   from_mask = 8'b0000_0111;
         OpNsub:  from_mask = 8'b0000_0011;
         OpXor:   from_mask = 8'b0101_0111;
         OpAbs:   from_mask = 8'b0000_1011;
         default: from_mask = 8'b0000_0000;
      endcase
      return from_mask[cur];
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command buffer for the sequencer: Depth entries (power of two), pointers wrap naturally,
// simultaneous push and pop keep the occupancy unchanged.
module alu_cmd_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 19
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [Width-1:0] push_data,
   input  logic             pop,
   output logic [Width-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [PtrW:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == FullCount);
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PtrW + 1)'(1);
            2'b01:   count_q <= count_q - (PtrW + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/alu_cmd_seq.sv
// Sequences buffered commands onto a stateful ALU, inserting a SUB bridge cycle when the
// ALU cannot move directly to the next op, and returns tagged results three cycles later.
module alu_cmd_seq
   import alu_cmd_seq_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk_p_i,
   input  logic        reset_n_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [2:0]  cmd_op_i,
   input  logic [7:0]  cmd_a_i,
   input  logic [7:0]  cmd_b_i,
   output logic [2:0]  alu_inst_o,
   output logic [7:0]  alu_a_o,
   output logic [7:0]  alu_b_o,
   input  logic [15:0] alu_data_i,
   output logic        rsp_valid_o,
   output logic [2:0]  rsp_op_o,
   output logic [15:0] rsp_data_o,
   output logic        err_o
);

   localparam int unsigned CmdW = $bits(alu_cmd_t);

   alu_cmd_t    in_cmd;
   alu_cmd_t    head_cmd;
   logic [CmdW-1:0] head_bits;
   logic        fifo_full;
   logic        fifo_empty;
   logic        pop;
   seq_state_e  state_d;
   seq_state_e  state_q;
   alu_op_e     shadow_q;
   alu_op_e     inst_q;
   logic [7:0]  a_q;
   logic [7:0]  b_q;
   logic        tag1_vld_q;
   alu_op_e     tag1_op_q;
   logic        tag2_vld_q;
   alu_op_e     tag2_op_q;
   logic        rsp_vld_q;
   alu_op_e     rsp_op_q;
   logic [15:0] rsp_data_q;
   logic        err_q;

   assign in_cmd      = '{op: alu_op_e'(cmd_op_i), a: cmd_a_i, b: cmd_b_i};
   assign head_cmd    = alu_cmd_t'(head_bits);
   assign cmd_ready_o = !fifo_full;

   alu_cmd_fifo #(
      .Depth (FIFO_DEPTH),
      .Width (CmdW)
   ) u_fifo (
      .clk       (clk_p_i),
      .rst_n     (reset_n_i),
      .push      (cmd_valid_i),
      .push_data (in_cmd),
      .pop       (pop),
      .head      (head_bits),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Decide what the ALU sees next cycle; an illegal head op is dropped via the idle path.
   always_comb begin
      pop     = 1'b0;
      state_d = StIdle;
      if (!fifo_empty) begin
         if (head_cmd.op == OpHold) begin
            pop = 1'b1;
         end else if (op_legal(shadow_q, head_cmd.op)) begin
            pop     = 1'b1;
            state_d = StIssue;
         end else begin
            state_d = StBridge;
         end
      end
   end

   always_ff @(posedge clk_p_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= StIdle;
         shadow_q   <= OpAdd;
         inst_q     <= OpHold;
         a_q        <= '0;
         b_q        <= '0;
         err_q      <= 1'b0;
         tag1_vld_q <= 1'b0;
         tag1_op_q  <= OpAdd;
         tag2_vld_q <= 1'b0;
         tag2_op_q  <= OpAdd;
         rsp_vld_q  <= 1'b0;
         rsp_op_q   <= OpAdd;
         rsp_data_q <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= 1'b0;
         unique case (state_d)
            StIssue: begin
               inst_q   <= head_cmd.op;
               a_q      <= head_cmd.a;
               b_q      <= head_cmd.b;
               shadow_q <= head_cmd.op;
            end
            StBridge: begin
               inst_q   <= OpSub;
               a_q      <= '0;
               b_q      <= '0;
               shadow_q <= OpSub;
            end
            default: begin
               inst_q <= OpHold;
               a_q    <= '0;
               b_q    <= '0;
               err_q  <= pop;
            end
         endcase
         // The ALU result for a command driven in cycle t is valid at the end of t+2.
         tag1_vld_q <= (state_q == StIssue);
         tag1_op_q  <= inst_q;
         tag2_vld_q <= tag1_vld_q;
         tag2_op_q  <= tag1_op_q;
         rsp_vld_q  <= tag2_vld_q;
         if (tag2_vld_q) begin
            rsp_op_q   <= tag2_op_q;
            rsp_data_q <= alu_data_i;
         end
      end
   end

   assign alu_inst_o  = inst_q;
   assign alu_a_o     = a_q;
   assign alu_b_o     = b_q;
   assign rsp_valid_o = rsp_vld_q;
   assign rsp_op_o    = rsp_op_q;
   assign rsp_data_o  = rsp_data_q;
   assign err_o       = err_q;

endmodule
